stage_sequencer: RTL and testbench

- Top-level control FSM for the multi-cycle core.
- Sequences the stages fetch -> decode -> exec -> mem -> write, one instruction at a time, using a one-cycle enable pulse and one-cycle done pulse per stage.
- Bypasses the mem stage when exec reports that no memory access is needed.
- Handles start/halt at instruction boundaries, counts retired instructions, and runs a per-stage watchdog.

---
 rtl/stage_sequencer.sv | 149 ++++++++++++++
 tb/tb_stage_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Top-level control FSM for the multi-cycle core: walks fetch/decode/exec/mem/write one
// instruction at a time, with halt at instruction boundaries and a per-stage watchdog.
module stage_sequencer #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned WD_W    = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        halt_req,
    output logic        fetch_enable,
    input  logic        fetch_done,
    output logic        decode_enable,
    input  logic        decode_done,
    output logic        exec_enable,
    input  logic        exec_done,
    input  logic        mem_skip,
    output logic        mem_enable,
    input  logic        mem_done,
    output logic        write_enable,
    input  logic        write_done,
    output logic        busy,
    output logic        halted,
    output logic        error,
    output logic [2:0]  error_stage,
    output logic [2:0]  cur_stage,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWrite  = 3'd5,
        StHalt   = 3'd6,
        StErr    = 3'd7
    } state_e;

    // Counter value in the last cycle a stage may spend without its done.
    localparam logic [WD_W-1:0] WdLast = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              stage_done;
    logic              halt_q;
    logic [WD_W-1:0]   wd_q;
    logic [31:0]       retired_q;
    logic              fetch_en_q, decode_en_q, exec_en_q, mem_en_q, write_en_q;
    logic              busy_q, halted_q, error_q;
    logic [2:0]        error_stage_q;

    function automatic logic in_stage(input state_e s);
        return (s inside {StFetch, StDecode, StExec, StMem, StWrite});
    endfunction

    always_comb begin
        state_d    = state_q;
        stage_done = 1'b0;
        case (state_q)
            StIdle, StHalt: if (start) state_d = StFetch;
            StFetch: begin
                stage_done = fetch_done;
                if (fetch_done) state_d = StDecode;
            end
            StDecode: begin
                stage_done = decode_done;
                if (decode_done) state_d = StExec;
            end
            StExec: begin
                stage_done = exec_done;
                if (exec_done) state_d = mem_skip ? StWrite : StMem;
            end
            StMem: begin
                stage_done = mem_done;
                if (mem_done) state_d = StWrite;
            end
            StWrite: begin
                stage_done = write_done;
                if (write_done) state_d = (halt_q || halt_req) ? StHalt : StFetch;
            end
            default: state_d = state_q;
        endcase
        // A done in the expiry cycle wins over the watchdog.
        if ((TIMEOUT != 0) && in_stage(state_q) && !stage_done && (wd_q == WdLast)) begin
            state_d = StErr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            halt_q        <= 1'b0;
            wd_q          <= '0;
            retired_q     <= '0;
            fetch_en_q    <= 1'b0;
            decode_en_q   <= 1'b0;
            exec_en_q     <= 1'b0;
            mem_en_q      <= 1'b0;
            write_en_q    <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            error_q       <= 1'b0;
            error_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_en_q  <= (state_d == StFetch)  && (state_q != StFetch);
            decode_en_q <= (state_d == StDecode) && (state_q != StDecode);
            exec_en_q   <= (state_d == StExec)   && (state_q != StExec);
            mem_en_q    <= (state_d == StMem)    && (state_q != StMem);
            write_en_q  <= (state_d == StWrite)  && (state_q != StWrite);
            busy_q      <= in_stage(state_d);
            halted_q    <= (state_d == StHalt);

            if ((state_d == StErr) && (state_q != StErr)) begin
                error_q       <= 1'b1;
                error_stage_q <= state_q;
            end

            if (state_d != state_q) begin
                wd_q <= '0;
            end else if (in_stage(state_q)) begin
                wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end

            if ((state_q == StWrite) && write_done) begin
                retired_q <= retired_q + 32'd1;
                halt_q    <= 1'b0;
            end else if (in_stage(state_q) && halt_req) begin
                halt_q <= 1'b1;
            end
        end
    end

    assign fetch_enable  = fetch_en_q;
    assign decode_enable = decode_en_q;
    assign exec_enable   = exec_en_q;
    assign mem_enable    = mem_en_q;
    assign write_enable  = write_en_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign error         = error_q;
    assign error_stage   = error_stage_q;
    assign cur_stage     = state_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with TIMEOUT=4; expected values are hand-computed.
module tb_stage_sequencer;

    logic        clk;
    logic        rstn;
    logic        start, halt_req;
    logic        fetch_enable, decode_enable, exec_enable, mem_enable, write_enable;
    logic        fetch_done, decode_done, exec_done, mem_skip, mem_done, write_done;
    logic        busy, halted, error;
    logic [2:0]  error_stage, cur_stage;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fails  = 0;

    stage_sequencer #(
        .TIMEOUT(4),
        .WD_W   (16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .halt_req     (halt_req),
        .fetch_enable (fetch_enable),
        .fetch_done   (fetch_done),
        .decode_enable(decode_enable),
        .decode_done  (decode_done),
        .exec_enable  (exec_enable),
        .exec_done    (exec_done),
        .mem_skip     (mem_skip),
        .mem_enable   (mem_enable),
        .mem_done     (mem_done),
        .write_enable (write_enable),
        .write_done   (write_done),
        .busy         (busy),
        .halted       (halted),
        .error        (error),
        .error_stage  (error_stage),
        .cur_stage    (cur_stage),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        start = 0; halt_req = 0; fetch_done = 0; decode_done = 0;
        exec_done = 0; mem_skip = 0; mem_done = 0; write_done = 0;
    endtask

    initial begin
        rstn = 0;
        clr();
        tick(); tick();
        check("rst_stage",   {29'd0, cur_stage}, 0);
        check("rst_busy",    {31'd0, busy}, 0);
        check("rst_halted",  {31'd0, halted}, 0);
        check("rst_error",   {31'd0, error}, 0);
        check("rst_retired", retired, 0);
        check("rst_fen",     {31'd0, fetch_enable}, 0);
        rstn = 1;

        // Single instruction with mem stage (c0 .. c10)
        start = 1; tick(); clr();                                     // c1
        check("t1_fen_c1",  {31'd0, fetch_enable}, 1);
        check("t1_stage_c1", {29'd0, cur_stage}, 1);
        check("t1_busy_c1", {31'd0, busy}, 1);
        tick();                                                       // c2
        check("t1_fen_c2",  {31'd0, fetch_enable}, 0);
        tick(); fetch_done = 1; tick(); clr();                        // c4
        check("t1_den_c4",  {31'd0, decode_enable}, 1);
        check("t1_stage_c4", {29'd0, cur_stage}, 2);
        decode_done = 1; tick(); clr();                               // c5
        check("t1_een_c5",  {31'd0, exec_enable}, 1);
        check("t1_den_c5",  {31'd0, decode_enable}, 0);
        tick(); exec_done = 1; mem_skip = 0; tick(); clr();           // c7
        check("t1_men_c7",  {31'd0, mem_enable}, 1);
        check("t1_stage_c7", {29'd0, cur_stage}, 4);
        tick(); mem_done = 1; tick(); clr();                          // c9
        check("t1_wen_c9",  {31'd0, write_enable}, 1);
        check("t1_stage_c9", {29'd0, cur_stage}, 5);
        write_done = 1; tick(); clr();                                // c10
        check("t1_retired", retired, 1);
        check("t1_fen_c10", {31'd0, fetch_enable}, 1);
        check("t1_stage_c10", {29'd0, cur_stage}, 1);

        // Spurious mem_done in D, then mem_skip, then halt_req coincident with write_done
        fetch_done = 1; tick(); clr();
        mem_done = 1; tick(); clr();
        check("t2_spur_stage", {29'd0, cur_stage}, 2);
        check("t2_spur_men",   {31'd0, mem_enable}, 0);
        check("t2_spur_err",   {31'd0, error}, 0);
        decode_done = 1; tick(); clr();
        exec_done = 1; mem_skip = 1; tick(); clr();
        check("t2_skip_stage", {29'd0, cur_stage}, 5);
        check("t2_skip_wen",   {31'd0, write_enable}, 1);
        check("t2_skip_men",   {31'd0, mem_enable}, 0);
        write_done = 1; halt_req = 1; tick(); clr();
        check("t2_halt_stage", {29'd0, cur_stage}, 6);
        check("t2_halted",     {31'd0, halted}, 1);
        check("t2_halt_busy",  {31'd0, busy}, 0);
        check("t2_retired",    retired, 2);
        check("t2_halt_fen",   {31'd0, fetch_enable}, 0);

        // Resume (start beats halt_req), halt_req during E
        start = 1; halt_req = 1; tick(); clr();
        check("t3_fen",    {31'd0, fetch_enable}, 1);
        check("t3_halted", {31'd0, halted}, 0);
        fetch_done = 1; tick(); clr();
        decode_done = 1; tick(); clr();
        halt_req = 1; tick(); clr();
        check("t3_e_stage", {29'd0, cur_stage}, 3);
        exec_done = 1; mem_skip = 1; tick(); clr();
        write_done = 1; tick(); clr();
        check("t3_stage",   {29'd0, cur_stage}, 6);
        check("t3_halted2", {31'd0, halted}, 1);
        check("t3_retired", retired, 3);
        check("t3_fen2",    {31'd0, fetch_enable}, 0);
        tick();
        check("t3_stay",    {29'd0, cur_stage}, 6);

        // Reset mid-E, then a late exec_done
        start = 1; tick(); clr();
        fetch_done = 1; tick(); clr();
        decode_done = 1; tick(); clr();
        check("t5_een", {31'd0, exec_enable}, 1);
        rstn = 0; tick(); rstn = 1;
        check("t5_stage",   {29'd0, cur_stage}, 0);
        check("t5_busy",    {31'd0, busy}, 0);
        check("t5_een2",    {31'd0, exec_enable}, 0);
        check("t5_retired", retired, 0);
        exec_done = 1; tick(); clr();
        check("t5_late_stage", {29'd0, cur_stage}, 0);
        check("t5_late_men",   {31'd0, mem_enable}, 0);
        check("t5_late_wen",   {31'd0, write_enable}, 0);

        // Watchdog: done in expiry cycle advances, then decode stall expires
        start = 1; tick(); clr();                                     // F1
        check("t4_fen", {31'd0, fetch_enable}, 1);
        tick(); tick(); tick();                                       // F4
        check("t4_f4_stage", {29'd0, cur_stage}, 1);
        fetch_done = 1; tick(); clr();                                // D1
        check("t4_d1_stage", {29'd0, cur_stage}, 2);
        check("t4_d1_err",   {31'd0, error}, 0);
        tick(); tick(); tick();                                       // D4
        check("t4_d4_stage", {29'd0, cur_stage}, 2);
        check("t4_d4_err",   {31'd0, error}, 0);
        tick();
        check("t4_err_stage",  {29'd0, cur_stage}, 7);
        check("t4_error",      {31'd0, error}, 1);
        check("t4_error_stage", {29'd0, error_stage}, 2);
        check("t4_err_busy",   {31'd0, busy}, 0);
        check("t4_err_halted", {31'd0, halted}, 0);
        check("t4_err_een",    {31'd0, exec_enable}, 0);
        decode_done = 1; start = 1; tick(); clr();
        check("t4_sticky_stage", {29'd0, cur_stage}, 7);
        check("t4_sticky_fen",   {31'd0, fetch_enable}, 0);
        check("t4_sticky_err",   {31'd0, error}, 1);
        rstn = 0; tick(); rstn = 1;
        check("t4_clr_err",   {31'd0, error}, 0);
        check("t4_clr_estg",  {29'd0, error_stage}, 0);
        check("t4_clr_stage", {29'd0, cur_stage}, 0);

        // Retired counter wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        check("t6_preload", retired, 32'hFFFF_FFFF);
        start = 1; tick(); clr();
        fetch_done = 1; tick(); clr();
        decode_done = 1; tick(); clr();
        exec_done = 1; mem_skip = 1; tick(); clr();
        write_done = 1; tick(); clr();
        check("t6_wrap", retired, 32'h0000_0000);
        check("t6_fen",  {31'd0, fetch_enable}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
